// File: rtl/subtractor_serial_if.sv
// Handshake/operand bundle for subtractor_serial.
// The oovf result bit exists only when SUBTRACTOR_SERIAL_OVERFLOW_EN is defined.
interface subtractor_serial_if #(
    parameter int MP_WIDTH = 4
);
    logic                istart;
    logic [MP_WIDTH-1:0] ia;
    logic [MP_WIDTH-1:0] ib;
    logic                ibin;
    logic [MP_WIDTH-1:0] odiff;
    logic                obout;
    logic                obusy;
    logic                odone;
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
    logic                oovf;

    modport master (
        output istart, ia, ib, ibin,
        input  odiff, obout, obusy, odone, oovf
    );

    modport slave (
        input  istart, ia, ib, ibin,
        output odiff, obout, obusy, odone, oovf
    );
`else
    modport master (
        output istart, ia, ib, ibin,
        input  odiff, obout, obusy, odone
    );

    modport slave (
        input  istart, ia, ib, ibin,
        output odiff, obout, obusy, odone
    );
`endif
endinterface

// File: rtl/subtractor_serial.sv
// Digit-serial unsigned subtractor: {obout, odiff} = ia - ib - ibin,
// MP_DIGIT bits per cycle, LSB first, behind a start/busy/done handshake.
// Optional signed-overflow output oovf: define SUBTRACTOR_SERIAL_OVERFLOW_EN.
module subtractor_serial #(
    parameter int MP_WIDTH = 4,
    parameter int MP_DIGIT = 1
) (
    input  logic                iclk,
    input  logic                irstn,
    subtractor_serial_if.slave  bus
);
    localparam int K  = MP_WIDTH / MP_DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [MP_WIDTH-1:0] a_q, a_d;
    logic [MP_WIDTH-1:0] b_q, b_d;
    logic [MP_WIDTH-1:0] res_q, res_d;
    logic [MP_WIDTH-1:0] diff_q, diff_d;
    logic                borrow_q, borrow_d;
    logic                bout_q, bout_d;
    logic [CW-1:0]       cnt_q, cnt_d;
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
    logic                sa_q, sa_d;
    logic                sb_q, sb_d;
    logic                ovf_q, ovf_d;
`endif

    logic                accept;
    logic                last_digit;
    logic [MP_DIGIT:0]   digit;
    logic [MP_WIDTH-1:0] res_next;

    assign accept     = bus.istart && (state_q != ST_RUN);
    assign last_digit = (cnt_q == CW'(K - 1));

    // Current digit a - b - borrow; the top bit is the outgoing digit borrow
    always_comb begin
        digit = {1'b0, a_q[MP_DIGIT-1:0]} - {1'b0, b_q[MP_DIGIT-1:0]}
              - {{MP_DIGIT{1'b0}}, borrow_q};
        // Result digits enter from the MSB side; after K shifts the LSB digit sits at bit 0
        res_next = res_q >> MP_DIGIT;
        res_next[MP_WIDTH-1 -: MP_DIGIT] = digit[MP_DIGIT-1:0];
    end

    // State register
    always_ff @(posedge iclk) begin
        if (!irstn) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.istart) state_d = ST_RUN;
            ST_RUN:  if (last_digit) state_d = ST_DONE;
            ST_DONE: state_d = bus.istart ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        bus.obusy = (state_q == ST_RUN);
        bus.odone = (state_q == ST_DONE);
    end

    // Datapath next values: capture on accept, shift one digit per RUN cycle
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        cnt_d    = cnt_q;
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
        sa_d     = sa_q;
        sb_d     = sb_q;
        ovf_d    = ovf_q;
`endif
        if (accept) begin
            a_d      = bus.ia;
            b_d      = bus.ib;
            borrow_d = bus.ibin;
            cnt_d    = '0;
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
            sa_d     = bus.ia[MP_WIDTH-1];
            sb_d     = bus.ib[MP_WIDTH-1];
`endif
        end else if (state_q == ST_RUN) begin
            a_d      = a_q >> MP_DIGIT;
            b_d      = b_q >> MP_DIGIT;
            res_d    = res_next;
            borrow_d = digit[MP_DIGIT];
            cnt_d    = cnt_q + CW'(1);
            if (last_digit) begin
                diff_d = res_next;
                bout_d = digit[MP_DIGIT];
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
                // Overflow only when operand signs differ and the result sign leaves the minuend's
                ovf_d  = (sa_q ^ sb_q) & (res_next[MP_WIDTH-1] ^ sa_q);
`endif
            end
        end
    end

    // Datapath registers, all cleared by reset
    always_ff @(posedge iclk) begin
        if (!irstn) begin
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            cnt_q    <= cnt_d;
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.odiff = diff_q;
    assign bus.obout = bout_q;
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
    assign bus.oovf  = ovf_q;
`endif

endmodule

// File: tb/tb_subtractor_serial.sv
// Self-checking bench for subtractor_serial: directed vectors, random operations
// with ignored mid-run starts, held-high back-to-back starts and reset aborts.
`timescale 1ns/1ps
module tb_subtractor_serial;
    localparam int W = 4;
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif
    localparam int K = W / D;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [W-1:0] exp_diff = '0;
    logic         exp_bout = 1'b0;
    logic         exp_ovf  = 1'b0;

    subtractor_serial_if #(.MP_WIDTH(W)) bus ();

    subtractor_serial #(.MP_WIDTH(W), .MP_DIGIT(D)) dut (
        .iclk  (clk),
        .irstn (rstn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands
    function automatic void model(input int a, input int b, input int bin,
                                  output logic [W-1:0] d, output logic bo, output logic ov);
        int u, sa, sb, s;
        u  = a - b - bin;
        bo = (u < 0);
        d  = W'(u + (1 << W));
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        s  = sa - sb - bin;
        ov = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
    endfunction

    task automatic check_results(input string tag);
        check({tag, "_diff"}, bus.odiff, exp_diff);
        check({tag, "_bout"}, bus.obout, exp_bout);
`ifdef SUBTRACTOR_SERIAL_OVERFLOW_EN
        check({tag, "_ovf"}, bus.oovf, exp_ovf);
`endif
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        bus.istart = 1'b1;
        bus.ia     = a;
        bus.ib     = b;
        bus.ibin   = bin;
    endtask

    // Expects istart already presented for (a,b,bin) before the coming edge.
    // mode 0: istart low during RUN; 1: random istart/operands; 2: istart held high.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input int mode, input bit chain,
                          input logic [W-1:0] na, input logic [W-1:0] nb, input logic nbin);
        logic [W-1:0] d;
        logic         bo, ov;
        model(int'(a), int'(b), int'(bin), d, bo, ov);
        @(posedge clk); #1;
        if (mode != 2) bus.istart = 1'b0;
        for (int k = 0; k < K; k++) begin
            check("run_busy", bus.obusy, 1);
            check("run_done", bus.odone, 0);
            check_results("run_hold");
            if (mode == 1) bus.istart = 1'($urandom);
            if (mode >= 1) begin
                bus.ia   = W'($urandom);
                bus.ib   = W'($urandom);
                bus.ibin = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        exp_diff = d;
        exp_bout = bo;
        exp_ovf  = ov;
        check("done_pulse", bus.odone, 1);
        check("done_busy", bus.obusy, 0);
        check_results("result");
        if (chain) launch(na, nb, nbin);
        else       bus.istart = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        check({tag, "_busy"}, bus.obusy, 0);
        check({tag, "_done"}, bus.odone, 0);
        check_results(tag);
    endtask

    task automatic single(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input int mode);
        launch(a, b, bin);
        run_op(a, b, bin, mode, 1'b0, '0, '0, 1'b0);
        idle_check("after");
    endtask

    logic [W-1:0] va [6];
    logic [W-1:0] vb [6];
    logic         vc [6];

    initial begin
        bus.istart = 1'b0;
        bus.ia     = '0;
        bus.ib     = '0;
        bus.ibin   = 1'b0;
        rstn       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.obusy, 0);
        check("rst_done", bus.odone, 0);
        check_results("rst");

        // Reset overrides a start; first cycle after release accepts it
        launch(4'd9, 4'd3, 1'b0);
        @(posedge clk); #1;
        check("rst_over_busy", bus.obusy, 0);
        check_results("rst_over");
        rstn = 1'b1;
        run_op(4'd9, 4'd3, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        idle_check("after_first");

        // Directed vectors
        single(4'd2,  4'd3,  1'b0, 0);
        single(4'd15, 4'd10, 1'b1, 0);
        single(4'd0,  4'd0,  1'b1, 0);
        single(4'd5,  4'd5,  1'b0, 0);
        single(4'd7,  4'd8,  1'b0, 0);
        single(4'd3,  4'd1,  1'b0, 0);
        single(4'd8,  4'd1,  1'b0, 0);
        single(4'd15, 4'd15, 1'b1, 0);

        // Random operations with noisy starts during RUN and idle gaps
        for (int i = 0; i < 40; i++) begin
            int gap;
            single(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 1)));
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                bus.ia = W'($urandom);
                bus.ib = W'($urandom);
                idle_check("gap");
            end
        end

        // istart held high: back-to-back accept in DONE, every K+1 cycles
        for (int i = 0; i < 6; i++) begin
            va[i] = W'($urandom);
            vb[i] = W'($urandom);
            vc[i] = 1'($urandom);
        end
        launch(va[0], vb[0], vc[0]);
        for (int i = 0; i < 6; i++) begin
            if (i < 5) run_op(va[i], vb[i], vc[i], 2, 1'b1, va[i+1], vb[i+1], vc[i+1]);
            else       run_op(va[i], vb[i], vc[i], 2, 1'b0, '0, '0, 1'b0);
        end
        idle_check("b2b_end");

        // Reset in cycle 2 of a run aborts it with no done
        launch(4'd12, 4'd1, 1'b0);
        @(posedge clk); #1;
        bus.istart = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        exp_diff = '0;
        exp_bout = 1'b0;
        exp_ovf  = 1'b0;
        check("abort_busy", bus.obusy, 0);
        check("abort_done", bus.odone, 0);
        check_results("abort");
        rstn = 1'b1;
        for (int c = 0; c < K + 3; c++) idle_check("abort_quiet");

        // Start in the first cycle after reset completes normally
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        launch(4'd6, 4'd9, 1'b1);
        run_op(4'd6, 4'd9, 1'b1, 0, 1'b0, '0, '0, 1'b0);
        idle_check("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule
